// File: rtl/alu_sched_1212508_if.sv
// Bus bundle for the two-requester ALU scheduler: two request channels,
// the ALU drive/result pins, and the response channel.
// The master modport is the outside world (requesters, ALU, consumer);
// the slave modport is the scheduler itself.
interface alu_sched_1212508_if #(
  parameter int N = 4
);
  // requester 0
  logic                req0_valid;
  logic                req0_ready;
  logic [2:0]          req0_op;
  logic signed [N-1:0] req0_a;
  logic signed [N-1:0] req0_b;
  // requester 1
  logic                req1_valid;
  logic                req1_ready;
  logic [2:0]          req1_op;
  logic signed [N-1:0] req1_a;
  logic signed [N-1:0] req1_b;
  // shared ALU datapath
  logic [2:0]          alu_sel;
  logic signed [N-1:0] alu_a;
  logic signed [N-1:0] alu_b;
  logic signed [N+2:0] alu_result;
  // response channel
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic signed [N+2:0] rsp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_sel, alu_a, alu_b,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_sel, alu_a, alu_b,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_sched_1212508.sv
// Two-requester scheduler for a shared multifunction ALU.
// One operation is in flight at a time: IDLE accepts a request, EXEC holds
// the operands on the ALU for LAT cycles, RESP holds the captured result
// until the consumer takes it.
// Optional feature: define ALU_SCHED_ROUND_ROBIN_EN for round-robin
// arbitration; without it requester 0 has fixed priority.
// LAT must lie in 1..15 (the countdown counter is 4 bits wide).
module alu_sched_1212508 #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_sched_1212508_if.slave      bus,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Countdown start: EXEC lasts cnt_load+1 cycles, i.e. exactly LAT.
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       pri;
  logic       accept0;
  logic       accept1;
  logic       accept;
  logic       grant_id;
  logic       sample_now;
  logic       rsp_fire;

  // Ready outputs are mutually exclusive under contention, so at most
  // one of these can be high in any cycle.
  assign accept0    = bus.req0_valid && bus.req0_ready;
  assign accept1    = bus.req1_valid && bus.req1_ready;
  assign accept     = accept0 || accept1;
  assign grant_id   = accept1;
  assign sample_now = (state == EXEC) && (cnt == 4'd0);
  assign rsp_fire   = (state == RESP) && bus.rsp_valid && bus.rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (sample_now) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; readies are also gated by reset so they
  // read 0 for the whole time rst_n is held low.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    busy           = (state != IDLE);
    if (rst_n && (state == IDLE)) begin
      bus.req0_ready = !bus.req1_valid || (pri == 1'b0);
      bus.req1_ready = !bus.req0_valid || (pri == 1'b1);
    end
  end

  // ALU drive registers: loaded only on an accept and otherwise held,
  // including after the operation has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_sel <= 3'd0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
    end else if (accept0) begin
      bus.alu_sel <= bus.req0_op;
      bus.alu_a   <= bus.req0_a;
      bus.alu_b   <= bus.req0_b;
    end else if (accept1) begin
      bus.alu_sel <= bus.req1_op;
      bus.alu_a   <= bus.req1_a;
      bus.alu_b   <= bus.req1_b;
    end
  end

  // Requester ID of the operation in flight; doubles as the response ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_id <= 1'b0;
    end else if (accept) begin
      bus.rsp_id <= grant_id;
    end
  end

  // Latency countdown: loaded on accept, decremented while EXEC waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == EXEC) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response capture: the ALU result is copied bit-for-bit and held
  // until the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else if (sample_now) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= bus.alu_result;
    end else if (rsp_fire) begin
      bus.rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SCHED_ROUND_ROBIN_EN
  // Round robin: after each grant the other requester gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri <= 1'b0;
    end else if (accept) begin
      pri <= !grant_id;
    end
  end
`else
  // Fixed priority: requester 0 always wins contention.
  assign pri = 1'b0;
`endif

endmodule

// File: doc/alu_sched_1212508.md
# alu_sched_1212508

Two-requester scheduler that shares the multifunction ALU datapath (operand inputs plus 3-bit operation select feeding the 8:1 result mux) between two independent clients. It accepts one operation at a time over valid/ready handshakes and registers the opcode and operands into the ALU for a fixed latency. It then captures the signed N+3-bit result and returns it with the originating requester's ID over a valid/ready response channel.

## Interface
- `N`, default 4: operand width. The ALU result width is N+3.
- `LAT`, default 2: number of EXEC cycles from issue to result sample. Legal range is 1..15.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req0_valid`, input, 1: requester 0 has an operation.
- `req0_ready`, output, 1: requester 0 is accepted this cycle.
- `req0_op`, input, 3: operation select.
- `req0_a`, `req0_b`, input, N each: signed operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `alu_sel`, output, 3: drives the ALU operation/mux select.
- `alu_a`, `alu_b`, output, N each: drive the ALU operands.
- `alu_result`, input, N+3: signed ALU output.
- `rsp_valid`, output, 1: a response is held.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_id`, output, 1: ID of the requester that issued the operation.
- `rsp_data`, output, N+3: signed captured result.
- `busy`, output, 1: high when the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - `req0_ready = !req1_valid || pri==0`
  - `req1_ready = !req0_valid || pri==1`
  - Ready outputs are combinational and are 0 in every other state. At most one handshake can occur per cycle.
  - On a handshake, latch op, a and b into the ALU drive registers and the requester ID into the ID register. Load `cnt = LAT-1`, then go to EXEC.
- EXEC:
  - `alu_sel`, `alu_a` and `alu_b` hold the latched values.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, register `alu_result` into `rsp_data`, set `rsp_valid`, and go to RESP.
- RESP:
  - `rsp_valid`, `rsp_data` and `rsp_id` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake, clear `rsp_valid` and go to IDLE.
  - There is no request acceptance in RESP.
- ALU drive registers keep their last values after the operation completes and change only on the next accept.
- Width rule: `rsp_data` is an exact N+3-bit copy of `alu_result`. There is no extension or truncation.
- All 8 opcodes are legal. The scheduler never interprets the opcode.
- Requester inputs are ignored outside an IDLE handshake. Changes to valid or data while not ready have no effect.

## Timing
- Reset values: `req*_ready` 0 while `rst_n` is low, `alu_sel` 0, `alu_a` 0, `alu_b` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `busy` 0, `cnt` 0, `pri` 0.
- If the request handshake occurs in cycle k:
  - `busy` is 1 from cycle k+1.
  - ALU inputs are valid from cycle k+1.
  - `alu_result` is sampled at the end of cycle k+LAT.
  - `rsp_valid` is 1 from cycle k+LAT+1.
- If the response handshake occurs in cycle r, the state is IDLE in cycle r+1 and a new accept is possible in r+1.
- Best-case throughput is one operation per LAT+2 cycles when `rsp_ready` is tied high.
- Reset asserted mid-operation (EXEC or RESP) aborts immediately:
  - All outputs return to their reset values.
  - The pending result is discarded.
  - `pri` returns to 0.
- If both requesters are valid in IDLE, only the requester selected by `pri` is ready. The other waits with its request held.

## Configuration
- `ALU_SCHED_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - On each accept, `pri` is set to the non-granted ID.
  - Under continuous contention, grants alternate 0, 1, 0, 1, ...
- `ALU_SCHED_ROUND_ROBIN_EN` undefined: fixed priority.
  - `pri` is held at 0, so requester 0 always wins contention.
  - Requester 1 is accepted only when `req0_valid` is 0 in IDLE.

## Test plan
- Reset check: assert `rst_n`=0 mid-EXEC with LAT=2 -> all outputs are 0 in the same cycle. After release, `busy`=0 and `req0_ready`=1 with `req1_valid`=0.
- Single op, N=4, LAT=2: req0 op=3'b001, a=4'sd5, b=-4'sd3 accepted in cycle k, with the ALU model returning 7'sd42 -> `alu_sel`=1, `alu_a`=5, `alu_b`=-3 from k+1. `rsp_valid`=1, `rsp_id`=0, `rsp_data`=42 at k+3.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` and `rsp_data` are stable, both readies are 0, and a new req1 is not accepted until the cycle after the response handshake.
- Contention with the macro defined: both requesters continuously valid, `rsp_ready`=1, 4 ops -> `rsp_id` sequence is 0, 1, 0, 1. With the macro undefined -> 0, 0, 0, 0.
- LAT=1 boundary: accept in cycle k -> exactly one EXEC cycle, and `rsp_valid` is 1 at k+2. A sign-boundary result of -64 (7'b1000000) is returned unchanged.
